// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (CPU port c_*, DMA port d_*), the arbiter and the
// single-port memory. The arbiter uses the slave modport; the requesters/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Handshake: a requester raises req with we/addr/wdata stable and holds it until it sees a
  // one-cycle ack; rdata is valid in that ack cycle. req high in the cycle after ack is a new request.
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_ack,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_ack,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and DMA accesses onto the unified single-port memory, sequencing MEM_LAT read latency.
// Define ARB_FIXED_PRIO_EN to give the CPU fixed priority; default build is round-robin.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                owner,
  output logic [1:0]          dbg_state
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          c_ack_q, c_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          grant_dma;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    grant_dma = bus.d_req & ~bus.c_req;
`else
    // On a tie the port that did not own the previous grant wins.
    grant_dma = bus.d_req & (~bus.c_req | ~last_q);
`endif
    sel_we    = grant_dma ? bus.d_we    : bus.c_we;
    sel_addr  = grant_dma ? bus.d_addr  : bus.c_addr;
    sel_wdata = grant_dma ? bus.d_wdata : bus.c_wdata;

    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    c_ack_d   = 1'b0;
    d_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.c_req | bus.d_req) begin
          state_d  = ISSUE;
          owner_d  = grant_dma;
          last_d   = grant_dma;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          mem_en_d = 1'b1;
          mem_we_d = sel_we;
        end
      end
      ISSUE: begin
        cnt_d   = LAT4;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          // mem_rdata is valid only in this last WAIT cycle.
          state_d = RESP;
          if (!we_q) begin
            if (owner_q) d_rdata_d = bus.mem_rdata;
            else         c_rdata_d = bus.mem_rdata;
          end
          c_ack_d = ~owner_q;
          d_ack_d = owner_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      c_ack_q   <= c_ack_d;
      d_ack_q   <= d_ack_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.c_ack     = c_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = busy_q;
  assign owner         = owner_q;
  assign dbg_state     = state_q;

endmodule
